// File: rtl/csa42_tree_pipe.sv
`timescale 1ns/1ps
`default_nettype none
// ---------------------------------------------------------------------------
// csa42_tree_pipe: pipelined 4:2 carry-save reduction tree with global stall.
// Define CSA_TREE_CPA_EN to add a registered carry-propagate stage (out_res).
// Revision: 1.0
// ---------------------------------------------------------------------------
module csa42_tree_pipe #(
  parameter int CSA_WIDTH = 16,
  parameter int CSA_OPS   = 8,
  localparam int OUT_W    = CSA_WIDTH + $clog2(CSA_OPS)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush,
  input  logic                         in_valid,
  input  logic [CSA_OPS*CSA_WIDTH-1:0] in_ops,
  input  logic [7:0]                   in_tag,
  output logic                         in_ready,
  output logic                         out_valid,
  input  logic                         out_ready,
`ifdef CSA_TREE_CPA_EN
  output logic [OUT_W-1:0]             out_res,
`else
  output logic [OUT_W-1:0]             out_sum,
  output logic [OUT_W-1:0]             out_carry,
`endif
  output logic [7:0]                   out_tag
);

  localparam int LEVELS = $clog2(CSA_OPS) - 1;
  // Every tree level's vectors live back to back in one node array.
  localparam int NODES  = 2 * CSA_OPS - 2;
`ifdef CSA_TREE_CPA_EN
  localparam int STAGES = LEVELS + 1;
`else
  localparam int STAGES = LEVELS;
`endif

  logic               advance;
  logic               accept;
  logic [STAGES-1:0]  vld;
  logic [STAGES-1:0]  load;
  logic [7:0]         tag_q [STAGES];
  logic [OUT_W-1:0]   node  [NODES];

  assign out_valid = vld[STAGES-1];
  assign advance   = out_ready || !out_valid;
  assign in_ready  = rst_n && !flush && advance;
  assign accept    = in_valid && in_ready;
  assign out_tag   = tag_q[STAGES-1];

  // Data registers only load real sets; bubbles just shift the valid bits.
  always_comb begin
    load    = '0;
    load[0] = advance && accept;
    for (int s = 1; s < STAGES; s++) begin
      load[s] = advance && vld[s-1];
    end
  end

  for (genvar k = 0; k < CSA_OPS; k++) begin : g_ext
    assign node[k] = {{(OUT_W-CSA_WIDTH){1'b0}}, in_ops[k*CSA_WIDTH +: CSA_WIDTH]};
  end

  for (genvar l = 0; l < LEVELS; l++) begin : g_lvl
    localparam int NIN  = CSA_OPS >> l;
    localparam int IOFF = 2 * CSA_OPS - ((2 * CSA_OPS) >> l);
    localparam int OOFF = IOFF + NIN;

    logic [OUT_W-1:0] d [NIN/2];
    logic [OUT_W-1:0] q [NIN/2];

    for (genvar g = 0; g < NIN/4; g++) begin : g_grp
      logic [OUT_W-1:0] a, b, c, e, s1, t;
      assign a  = node[IOFF+4*g];
      assign b  = node[IOFF+4*g+1];
      assign c  = node[IOFF+4*g+2];
      assign e  = node[IOFF+4*g+3];
      assign s1 = a ^ b ^ c;
      assign t  = ((a & b) | (a & c) | (b & c)) << 1;
      assign d[2*g]   = s1 ^ e ^ t;
      assign d[2*g+1] = ((s1 & e) | (s1 & t) | (e & t)) << 1;
    end

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        for (int k = 0; k < NIN/2; k++) q[k] <= '0;
      end else if (load[l]) begin
        for (int k = 0; k < NIN/2; k++) q[k] <= d[k];
      end
    end

    for (genvar k = 0; k < NIN/2; k++) begin : g_out
      assign node[OOFF+k] = q[k];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld <= '0;
      for (int s = 0; s < STAGES; s++) tag_q[s] <= '0;
    end else begin
      if (advance) begin
        for (int s = STAGES-1; s > 0; s--) vld[s] <= vld[s-1];
        vld[0] <= accept;
      end
      for (int s = STAGES-1; s > 0; s--) begin
        if (load[s]) tag_q[s] <= tag_q[s-1];
      end
      if (load[0]) tag_q[0] <= in_tag;
      if (flush) vld <= '0;
    end
  end

`ifdef CSA_TREE_CPA_EN
  logic [OUT_W-1:0] res_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      res_q <= '0;
    end else if (load[STAGES-1]) begin
      res_q <= node[NODES-2] + node[NODES-1];
    end
  end

  assign out_res = res_q;
`else
  assign out_sum   = node[NODES-2];
  assign out_carry = node[NODES-1];
`endif

endmodule
`default_nettype wire

// File: tb/tb_csa42_tree_pipe.sv
`timescale 1ns/1ps
`default_nettype none
// Scoreboard bench for csa42_tree_pipe (CSA_WIDTH=16, CSA_OPS=8).
module tb_csa42_tree_pipe;
  localparam int W     = 16;
  localparam int OPS   = 8;
  localparam int OUT_W = 19;
`ifdef CSA_TREE_CPA_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             flush = 1'b0;
  logic             in_valid = 1'b0;
  logic             out_ready = 1'b1;
  logic [OPS*W-1:0] in_ops = '0;
  logic [7:0]       in_tag = '0;
  logic             in_ready, out_valid;
  logic [7:0]       out_tag;
  logic [OUT_W-1:0] got;
  logic [2*OUT_W+7:0] obs;
`ifdef CSA_TREE_CPA_EN
  logic [OUT_W-1:0] out_res;
  assign got = out_res;
  assign obs = {{OUT_W{1'b0}}, out_res, out_tag};
`else
  logic [OUT_W-1:0] out_sum, out_carry;
  assign got = out_sum + out_carry;
  assign obs = {out_sum, out_carry, out_tag};
`endif

  csa42_tree_pipe #(.CSA_WIDTH(W), .CSA_OPS(OPS)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid),
    .in_ops(in_ops), .in_tag(in_tag), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready),
`ifdef CSA_TREE_CPA_EN
    .out_res(out_res),
`else
    .out_sum(out_sum), .out_carry(out_carry),
`endif
    .out_tag(out_tag)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0]       tag;
    logic [OUT_W-1:0] val;
  } exp_t;

  exp_t sb[$];
  int   pop_cyc[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  bit   done = 1'b0;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [63:0] actual, input logic [63:0] required);
    checks++;
    if (actual !== required) begin
      failures++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, actual, required);
    end
  endtask

  // Monitor: every handshaken result is matched against the oldest expectation.
  always @(negedge clk) begin : mon
    exp_t e;
    if (rst_n && out_valid && out_ready) begin
      pop_cyc.push_back(cyc);
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_result: actual tag=0x%0h value=0x%0h required=no pending set", out_tag, got);
      end else begin
        e = sb.pop_front();
        check("result_value", 64'(got), 64'(e.val));
        check("result_tag", 64'(out_tag), 64'(e.tag));
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [OPS*W-1:0] fill(input logic [W-1:0] v);
    logic [OPS*W-1:0] r;
    for (int k = 0; k < OPS; k++) r[k*W +: W] = v;
    return r;
  endfunction

  function automatic logic [OPS*W-1:0] pack_seq(input logic [W-1:0] start, input logic [W-1:0] step);
    logic [OPS*W-1:0] r;
    logic [W-1:0] v;
    v = start;
    for (int k = 0; k < OPS; k++) begin
      r[k*W +: W] = v;
      v = v + step;
    end
    return r;
  endfunction

  function automatic logic [OUT_W-1:0] golden(input logic [OPS*W-1:0] ops);
    logic [OUT_W-1:0] s;
    s = '0;
    for (int k = 0; k < OPS; k++) s = s + OUT_W'(ops[k*W +: W]);
    return s;
  endfunction

  task automatic drive(input logic [OPS*W-1:0] ops, input logic [7:0] tag,
                       input logic [OUT_W-1:0] ev, output int waited);
    in_valid = 1'b1;
    in_ops   = ops;
    in_tag   = tag;
    waited   = 0;
    while (1) begin
      @(negedge clk);
      if (in_ready) begin
        sb.push_back({tag, ev});
        tick();
        break;
      end
      tick();
      waited++;
      if (waited > 1000) begin
        checks++;
        failures++;
        $display("FAIL drive_timeout: actual in_ready=0 for %0d cycles required=accept", waited);
        break;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    lat = 1;
    @(negedge clk);
    while (!out_valid && lat < 50) begin
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic drain;
    int n;
    n = 0;
    out_ready = 1'b1;
    while (sb.size() != 0 && n < 500) begin
      tick();
      n++;
    end
    check("drain_empty", 64'(sb.size()), 64'd0);
    repeat (3) tick();
  endtask

  initial begin
    int w0, w1, w2, lat, span;
    logic [2*OUT_W+7:0] snap;
    logic [OPS*W-1:0] rops;

    // Reset state
    repeat (3) tick();
    @(negedge clk);
    check("reset_out_valid", 64'(out_valid), 64'd0);
    check("reset_outputs", 64'(obs), 64'd0);
    check("reset_in_ready", 64'(in_ready), 64'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("release_in_ready", 64'(in_ready), 64'd1);
    tick();

    // All ones
    drive(fill(16'hFFFF), 8'h5A, 19'h7FFF8, w0);
    wait_valid(lat);
    check("latency_all_ones", 64'(lat), 64'(LAT));
    tick();
    drain();

    // Back-to-back sets
    pop_cyc.delete();
    drive(pack_seq(16'd1, 16'd1), 8'h01, 19'd36, w0);
    drive(fill(16'h1000), 8'h02, 19'h08000, w1);
    drive(fill(16'h0000), 8'h03, 19'd0, w2);
    check("b2b_accept_waits", 64'(w0 + w1 + w2), 64'd0);
    drain();
    check("b2b_count", 64'(pop_cyc.size()), 64'd3);
    span = (pop_cyc.size() >= 3) ? pop_cyc[2] - pop_cyc[0] : -1;
    check("b2b_consecutive", 64'(span), 64'd2);

    // Stall with sets issued while downstream is blocked
    out_ready = 1'b0;
    fork
      begin
        drive(fill(16'h0001), 8'h21, 19'd8, w0);
        drive(pack_seq(16'd0, 16'd1), 8'h22, 19'd28, w1);
        drive(fill(16'h8000), 8'h23, 19'h40000, w2);
      end
      begin
        wait_valid(lat);
        snap = obs;
        repeat (4) begin
          @(negedge clk);
          check("stall_in_ready", 64'(in_ready), 64'd0);
          check("stall_hold", 64'(obs), 64'(snap));
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();

    // Flush with two sets in flight
    drive(fill(16'h0003), 8'h31, 19'd24, w0);
    drive(fill(16'h0005), 8'h32, 19'd40, w1);
    flush = 1'b1;
    @(negedge clk);
    check("flush_in_ready", 64'(in_ready), 64'd0);
    @(posedge clk);
    #1 flush = 1'b0;
    sb.delete();
    repeat (4) begin
      @(negedge clk);
      check("flush_no_valid", 64'(out_valid), 64'd0);
    end
    tick();
    drive(fill(16'h0002), 8'h11, 19'd16, w0);
    wait_valid(lat);
    check("flush_next_latency", 64'(lat), 64'(LAT));
    tick();
    drain();

    // One-cycle reset with two sets in flight
    drive(fill(16'h0007), 8'h41, 19'd56, w0);
    drive(fill(16'h0009), 8'h42, 19'd72, w1);
    rst_n = 1'b0;
    @(negedge clk);
    check("rst_cycle_in_ready", 64'(in_ready), 64'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    sb.delete();
    @(negedge clk);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_outputs", 64'(obs), 64'd0);
    check("rst_release_ready", 64'(in_ready), 64'd1);
    repeat (5) begin
      @(posedge clk);
      @(negedge clk);
      check("rst_no_stale", 64'(out_valid), 64'd0);
    end
    tick();

    // Random sets with random backpressure
    done = 1'b0;
    fork
      begin
        for (int i = 0; i < 10000; i++) begin
          for (int k = 0; k < OPS; k++) rops[k*W +: W] = W'($urandom);
          drive(rops, 8'(i), golden(rops), w0);
          if ($urandom_range(0, 3) == 0) tick();
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          out_ready = 1'($urandom_range(0, 1));
          tick();
        end
        out_ready = 1'b1;
      end
    join
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/csa42_tree_pipe.md
CSA42_TREE_PIPE -- requirements
Module: csa42_tree_pipe

Interface
REQ-001 Parameter CSA_WIDTH, default 16: operand width in bits (range 4..64).
REQ-002 Parameter CSA_OPS, default 8: operand count (power of two, 4..16).
REQ-003 Derived constants:
  - OUT_W = CSA_WIDTH + log2(CSA_OPS).
  - LEVELS = log2(CSA_OPS) - 1, the number of 4:2 reduction levels.
REQ-004 clk  input  1  single clock; all flops on its rising edge.
REQ-005 rst_n  input  1  synchronous, active-low reset.
REQ-006 flush  input  1  synchronous pipeline clear.
REQ-007 in_valid  input  1  operand set valid.
REQ-008 in_ops  input  CSA_OPS*CSA_WIDTH  packed unsigned operands; operand k at bits [k*CSA_WIDTH +: CSA_WIDTH].
REQ-009 in_tag  input  8  sideband, carried alongside its operand set.
REQ-010 in_ready  output  1  block accepts an operand set this cycle.
REQ-011 out_valid  output  1  result valid.
REQ-012 out_ready  input  1  downstream accepts the result.
REQ-013 out_sum, out_carry  output  OUT_W each  redundant result (present only without CSA_TREE_CPA_EN).
REQ-014 out_res  output  OUT_W  resolved result (present only with CSA_TREE_CPA_EN).
REQ-015 out_tag  output  8  tag of the result currently presented.

Function
REQ-016 Operands are zero-extended to OUT_W before reduction.
REQ-017 Each level reduces groups of four vectors to two using the 4:2 compressor recurrence; the intermediate carry is shifted left one bit; all bits above OUT_W-1 are discarded.
REQ-018 Each level output is registered together with a per-level valid bit and the tag.
REQ-019 Latency:
  - in_valid&&in_ready at cycle t gives out_valid at t+LEVELS when no stall occurs.
  - LEVELS = 2 for CSA_OPS=8.
REQ-020 Arithmetic contract: (out_sum+out_carry) mod 2^OUT_W equals the exact sum of the accepted operands.
REQ-021 Global stall rule:
  - advance = out_ready || !out_valid.
  - All level registers load only when advance=1.
  - in_ready = advance.
REQ-022 A bubble (in_valid=0 on advance) inserts valid=0 into level 1; bubbles collapse because the stage loads whenever the output is empty.
REQ-023 While out_valid=1 and out_ready=0:
  - out_sum, out_carry, out_res and out_tag hold stable.
  - No new set is accepted.
REQ-024 Throughput: one set per cycle while out_ready=1.
REQ-025 Result order equals acceptance order; no reordering or dropping.
REQ-026 flush=1:
  - All level valid bits clear at the next edge.
  - in_ready is forced 0 that cycle.
  - Data registers may keep stale values.
REQ-027 flush has priority over acceptance and advance.
REQ-028 A result handshaken (out_ready=1) in the same cycle as flush counts as delivered.
REQ-029 in_ops and in_tag are ignored when in_valid=0 or in_ready=0.

Reset
REQ-030 When rst_n=0 at a clock edge, all level valid bits clear.
REQ-031 During and after reset:
  - out_valid=0.
  - out_sum, out_carry, out_res and out_tag are 0.
  - in_ready=0 during the reset cycle.
REQ-032 Reset mid-operation discards every in-flight set; no partial result appears after release.
REQ-033 in_ready=1 in the first cycle after rst_n returns high.

Configuration
REQ-034 Macro CSA_TREE_CPA_EN is defined:
  - An extra registered carry-propagate stage computes out_res = (sum+carry) mod 2^OUT_W.
  - Latency becomes LEVELS+1.
  - out_sum and out_carry are absent.
  - The stall rule of REQ-021 extends to this stage.
REQ-035 Macro CSA_TREE_CPA_EN is undefined: the redundant outputs are presented; latency is LEVELS; out_res is absent.

Verification (CSA_WIDTH=16, CSA_OPS=8, OUT_W=19)
REQ-036 All eight operands 0xFFFF, tag 0x5A, out_ready=1:
  - Without the macro: out_valid at cycle 2 with (sum+carry) mod 2^19 = 0x7FFF8 and out_tag = 0x5A.
  - With the macro: out_res = 0x7FFF8 at cycle 3.
REQ-037 Back-to-back sets 1..8, 0x1000 x8, 0 x8 with out_ready=1 -> results 36, 0x8000, 0 on three consecutive cycles, in order.
REQ-038 Stall:
  - Three sets are issued while out_ready=0 from cycle 2 to 6.
  - in_ready=0 during the stall and the held result is stable.
  - The results are released in order after out_ready returns to 1.
REQ-039 Two sets in flight, then flush=1 for one cycle -> out_valid stays 0 thereafter; the next set (tag 0x11) emerges after full latency.
REQ-040 rst_n=0 for one cycle with two sets in flight:
  - All outputs are 0.
  - in_ready=1 on the next cycle.
  - No stale result appears.
REQ-041 10,000 random operand sets with random out_ready (50%) -> every result matches the golden sum mod 2^19, in order, with no loss or duplication.
